// File: rtl/io_arbiter.sv
// rtl/io_arbiter.sv - two-master round-robin arbiter and command sequencer in front of io_space
module io_arbiter #(
    parameter int RAM_DEPTH = 14
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 M0_REQ,
    input  logic                 M0_WE,
    input  logic                 M0_RE,
    input  logic                 M0_KILL,
    input  logic [RAM_DEPTH-1:0] M0_ADDR,
    input  logic [31:0]          M0_WD,
    output logic                 M0_ACK,
    output logic [31:0]          M0_RD,
    input  logic                 M1_REQ,
    input  logic                 M1_WE,
    input  logic                 M1_RE,
    input  logic [RAM_DEPTH-1:0] M1_ADDR,
    input  logic [31:0]          M1_WD,
    output logic                 M1_ACK,
    output logic [31:0]          M1_RD,
    output logic                 IO_REQ,
    output logic                 IO_DBE,
    output logic                 IO_WE,
    output logic                 IO_RE,
    output logic [RAM_DEPTH-1:0] IO_ADDR,
    output logic [31:0]          IO_WD,
    input  logic [31:0]          IO_RD,
    output logic                 BUSY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   winner_q, winner_d;
    logic                   cmd_we_q, cmd_we_d;
    logic                   cmd_re_q, cmd_re_d;
    logic [RAM_DEPTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [31:0]            cmd_wd_q, cmd_wd_d;
    logic                   grant;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_re_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wd_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            cmd_we_q     <= cmd_we_d;
            cmd_re_q     <= cmd_re_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wd_q     <= cmd_wd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        cmd_we_d     = cmd_we_q;
        cmd_re_d     = cmd_re_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wd_d     = cmd_wd_q;
        // On a tie the master that did not win last time gets the channel.
        grant        = (M0_REQ && M1_REQ) ? ~last_grant_q : M1_REQ;

        IO_REQ  = 1'b0;
        IO_DBE  = 1'b0;
        IO_WE   = 1'b0;
        IO_RE   = 1'b0;
        IO_ADDR = cmd_addr_q;
        IO_WD   = cmd_wd_q;
        M0_ACK  = 1'b0;
        M1_ACK  = 1'b0;
        M0_RD   = '0;
        M1_RD   = '0;
        BUSY    = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (M0_REQ || M1_REQ) begin
                    state_d      = S_ISSUE;
                    winner_d     = grant;
                    last_grant_d = grant;
                    cmd_we_d     = grant ? M1_WE   : M0_WE;
                    cmd_re_d     = grant ? M1_RE   : M0_RE;
                    cmd_addr_d   = grant ? M1_ADDR : M0_ADDR;
                    cmd_wd_d     = grant ? M1_WD   : M0_WD;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                IO_REQ  = 1'b1;
                IO_WE   = cmd_we_q;
                IO_RE   = cmd_re_q;
                // A CPU pipeline flush in this cycle cancels the access inside io_space.
                IO_DBE  = ~winner_q & M0_KILL;
            end
            S_WAIT: begin
                state_d = S_IDLE;
                if (winner_q) begin
                    M1_ACK = 1'b1;
                    M1_RD  = IO_RD;
                end else begin
                    M0_ACK = 1'b1;
                    M0_RD  = IO_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_io_arbiter.sv
// tb/tb_io_arbiter.sv - directed vector table, fairness sequence and randomized model check for io_arbiter
module tb_io_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        M0_REQ, M0_WE, M0_RE, M0_KILL;
    logic [13:0] M0_ADDR;
    logic [31:0] M0_WD;
    logic        M0_ACK;
    logic [31:0] M0_RD;
    logic        M1_REQ, M1_WE, M1_RE;
    logic [13:0] M1_ADDR;
    logic [31:0] M1_WD;
    logic        M1_ACK;
    logic [31:0] M1_RD;
    logic        IO_REQ, IO_DBE, IO_WE, IO_RE;
    logic [13:0] IO_ADDR;
    logic [31:0] IO_WD;
    logic [31:0] IO_RD;
    logic        BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    io_arbiter #(.RAM_DEPTH(14)) dut (
        .CLK(CLK), .RESET(RESET),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_RE(M0_RE), .M0_KILL(M0_KILL),
        .M0_ADDR(M0_ADDR), .M0_WD(M0_WD), .M0_ACK(M0_ACK), .M0_RD(M0_RD),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_RE(M1_RE),
        .M1_ADDR(M1_ADDR), .M1_WD(M1_WD), .M1_ACK(M1_ACK), .M1_RD(M1_RD),
        .IO_REQ(IO_REQ), .IO_DBE(IO_DBE), .IO_WE(IO_WE), .IO_RE(IO_RE),
        .IO_ADDR(IO_ADDR), .IO_WD(IO_WD), .IO_RD(IO_RD), .BUSY(BUSY)
    );

    typedef struct {
        logic        rst;
        logic        r0, w0, e0, k0;
        logic [13:0] a0;
        logic [31:0] d0;
        logic        r1, w1, e1;
        logic [13:0] a1;
        logic [31:0] d1;
        logic [31:0] iord;
        logic        x_req, x_dbe, x_we, x_re;
        logic [13:0] x_addr;
        logic [31:0] x_wd;
        logic        x_ack0;
        logic [31:0] x_rd0;
        logic        x_ack1;
        logic [31:0] x_rd1;
        logic        x_busy;
        logic        skip_rd0;
    } vec_t;

    vec_t tbl[31];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic r0, input logic w0, input logic e0, input logic k0,
                         input logic [13:0] a0, input logic [31:0] d0, input logic r1, input logic w1,
                         input logic e1, input logic [13:0] a1, input logic [31:0] d1, input logic [31:0] iord);
        RESET = rst;
        M0_REQ = r0; M0_WE = w0; M0_RE = e0; M0_KILL = k0; M0_ADDR = a0; M0_WD = d0;
        M1_REQ = r1; M1_WE = w1; M1_RE = e1; M1_ADDR = a1; M1_WD = d1;
        IO_RD = iord;
    endtask

    task automatic check_outs(input string tag, input logic req, input logic dbe, input logic we, input logic re,
                              input logic [13:0] addr, input logic [31:0] wd, input logic ack0, input logic [31:0] rd0,
                              input logic ack1, input logic [31:0] rd1, input logic busy, input logic skip_rd0);
        chk({tag, ".io_req"},  {31'd0, IO_REQ}, {31'd0, req});
        chk({tag, ".io_dbe"},  {31'd0, IO_DBE}, {31'd0, dbe});
        chk({tag, ".io_we"},   {31'd0, IO_WE},  {31'd0, we});
        chk({tag, ".io_re"},   {31'd0, IO_RE},  {31'd0, re});
        chk({tag, ".io_addr"}, {18'd0, IO_ADDR}, {18'd0, addr});
        chk({tag, ".io_wd"},   IO_WD, wd);
        chk({tag, ".m0_ack"},  {31'd0, M0_ACK}, {31'd0, ack0});
        if (!skip_rd0) chk({tag, ".m0_rd"}, M0_RD, rd0);
        chk({tag, ".m1_ack"},  {31'd0, M1_ACK}, {31'd0, ack1});
        chk({tag, ".m1_rd"},   M1_RD, rd1);
        chk({tag, ".busy"},    {31'd0, BUSY}, {31'd0, busy});
    endtask

    // Transaction-level reference: a grant at cycle c schedules the command at c+1, the
    // acknowledge at c+2, and the next arbitration at c+3.
    int          m_iss, m_ack, m_free, m_last, m_win;
    logic        m_we, m_re, m_killed;
    logic [13:0] m_addr;
    logic [31:0] m_wd;

    task automatic model_reset(input int c);
        m_iss = -1; m_ack = -1; m_free = c + 1; m_last = 1; m_win = 0;
        m_we = 0; m_re = 0; m_addr = 0; m_wd = 0; m_killed = 0;
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] XW = 32'h12345678;

    initial begin
        tbl[0]  = '{1, 0,0,0,0,0,0,           0,0,0,0,0,            0,
                    0,0,0,0,0,0,               0,0,0,0,              0,0};
        tbl[1]  = '{0, 1,0,1,0,14'h3,0,       0,0,0,0,0,            0,
                    0,0,0,0,0,0,               0,0,0,0,              0,0};
        tbl[2]  = '{0, 1,0,1,0,14'h3,0,       0,0,0,0,0,            0,
                    1,0,0,1,14'h3,0,           0,0,0,0,              1,0};
        tbl[3]  = '{0, 1,0,1,0,14'h3,0,       0,0,0,0,0,            DB,
                    0,0,0,0,14'h3,0,           1,DB,0,0,             1,0};
        tbl[4]  = '{0, 0,0,0,0,0,0,           0,0,0,0,0,            DB,
                    0,0,0,0,14'h3,0,           0,0,0,0,              0,0};
        tbl[5]  = '{1, 0,0,0,0,0,0,           0,0,0,0,0,            0,
                    0,0,0,0,14'h3,0,           0,0,0,0,              0,0};
        tbl[6]  = '{0, 1,1,0,0,14'h1,XW,      1,0,1,14'h2,0,        0,
                    0,0,0,0,0,0,               0,0,0,0,              0,0};
        tbl[7]  = '{0, 1,1,0,0,14'h1,XW,      1,0,1,14'h2,0,        0,
                    1,0,1,0,14'h1,XW,          0,0,0,0,              1,0};
        tbl[8]  = '{0, 1,1,0,0,14'h1,XW,      1,0,1,14'h2,0,        32'hA5A5A5A5,
                    0,0,0,0,14'h1,XW,          1,32'hA5A5A5A5,0,0,   1,0};
        tbl[9]  = '{0, 0,0,0,0,0,0,           1,0,1,14'h2,0,        32'hA5A5A5A5,
                    0,0,0,0,14'h1,XW,          0,0,0,0,              0,0};
        tbl[10] = '{0, 0,0,0,0,0,0,           1,0,1,14'h2,0,        0,
                    1,0,0,1,14'h2,0,           0,0,0,0,              1,0};
        tbl[11] = '{0, 0,0,0,0,0,0,           1,0,1,14'h2,0,        32'h0BADF00D,
                    0,0,0,0,14'h2,0,           0,0,1,32'h0BADF00D,   1,0};
        tbl[12] = '{0, 0,0,0,0,0,0,           0,0,0,0,0,            0,
                    0,0,0,0,14'h2,0,           0,0,0,0,              0,0};
        tbl[13] = '{0, 1,1,0,0,14'h44,32'h55, 0,0,0,0,0,            0,
                    0,0,0,0,14'h2,0,           0,0,0,0,              0,0};
        tbl[14] = '{0, 1,1,0,1,14'h44,32'h55, 0,0,0,0,0,            0,
                    1,1,1,0,14'h44,32'h55,     0,0,0,0,              1,0};
        tbl[15] = '{0, 1,1,0,1,14'h44,32'h55, 0,0,0,0,0,            32'h77,
                    0,0,0,0,14'h44,32'h55,     1,0,0,0,              1,1};
        tbl[16] = '{0, 0,0,0,1,0,0,           0,0,0,0,0,            0,
                    0,0,0,0,14'h44,32'h55,     0,0,0,0,              0,0};
        tbl[17] = '{0, 1,1,0,1,14'h45,32'h66, 0,0,0,0,0,            0,
                    0,0,0,0,14'h44,32'h55,     0,0,0,0,              0,0};
        tbl[18] = '{0, 1,1,0,0,14'h45,32'h66, 0,0,0,0,0,            0,
                    1,0,1,0,14'h45,32'h66,     0,0,0,0,              1,0};
        tbl[19] = '{0, 1,1,0,1,14'h45,32'h66, 0,0,0,0,0,            32'h88,
                    0,0,0,0,14'h45,32'h66,     1,32'h88,0,0,         1,0};
        tbl[20] = '{0, 0,0,0,0,0,0,           0,0,0,0,0,            0,
                    0,0,0,0,14'h45,32'h66,     0,0,0,0,              0,0};
        tbl[21] = '{0, 0,0,0,0,0,0,           1,0,1,14'h10,0,       0,
                    0,0,0,0,14'h45,32'h66,     0,0,0,0,              0,0};
        tbl[22] = '{0, 0,0,0,0,0,0,           1,0,1,14'h20,0,       0,
                    1,0,0,1,14'h10,0,          0,0,0,0,              1,0};
        tbl[23] = '{0, 0,0,0,0,0,0,           1,0,1,14'h20,0,       32'h99,
                    0,0,0,0,14'h10,0,          0,0,1,32'h99,         1,0};
        tbl[24] = '{0, 0,0,0,0,0,0,           0,0,0,0,0,            0,
                    0,0,0,0,14'h10,0,          0,0,0,0,              0,0};
        tbl[25] = '{0, 0,0,0,0,0,0,           1,1,1,14'h123,32'hCAFE, 0,
                    0,0,0,0,14'h10,0,          0,0,0,0,              0,0};
        tbl[26] = '{1, 0,0,0,0,0,0,           1,1,1,14'h123,32'hCAFE, 0,
                    1,0,1,1,14'h123,32'hCAFE,  0,0,0,0,              1,0};
        tbl[27] = '{0, 0,0,0,0,0,0,           1,0,1,14'h124,0,      32'h1111,
                    0,0,0,0,0,0,               0,0,0,0,              0,0};
        tbl[28] = '{0, 0,0,0,0,0,0,           1,0,1,14'h124,0,      0,
                    1,0,0,1,14'h124,0,         0,0,0,0,              1,0};
        tbl[29] = '{0, 0,0,0,0,0,0,           1,0,1,14'h124,0,      32'h2222,
                    0,0,0,0,14'h124,0,         0,0,1,32'h2222,       1,0};
        tbl[30] = '{0, 0,0,0,0,0,0,           0,0,0,0,0,            0,
                    0,0,0,0,14'h124,0,         0,0,0,0,              0,0};

        drive(1, 0,0,0,0,0,0, 0,0,0,0,0, 0);
        repeat (2) @(posedge CLK);

        for (int i = 0; i < 31; i++) begin
            @(posedge CLK); #1;
            drive(tbl[i].rst, tbl[i].r0, tbl[i].w0, tbl[i].e0, tbl[i].k0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].e1, tbl[i].a1, tbl[i].d1, tbl[i].iord);
            @(negedge CLK);
            check_outs($sformatf("vec%0d", i), tbl[i].x_req, tbl[i].x_dbe, tbl[i].x_we, tbl[i].x_re,
                       tbl[i].x_addr, tbl[i].x_wd, tbl[i].x_ack0, tbl[i].x_rd0, tbl[i].x_ack1,
                       tbl[i].x_rd1, tbl[i].x_busy, tbl[i].skip_rd0);
        end

        // Fairness: both masters keep requesting; grants must alternate starting with master 0.
        begin
            int who[$];
            int when[$];
            @(posedge CLK); #1;
            drive(1, 0,0,0,0,0,0, 0,0,0,0,0, 0);
            for (int c = 0; c < 40 && who.size() < 6; c++) begin
                @(posedge CLK); #1;
                drive(0, 1,0,1,0,14'h100,0, 1,0,1,14'h200,0, 32'h5000 + c);
                @(negedge CLK);
                if (M0_ACK && M1_ACK) chk($sformatf("fair.both_ack@%0d", c), 1, 0);
                if (M0_ACK) begin who.push_back(0); when.push_back(c); end
                if (M1_ACK) begin who.push_back(1); when.push_back(c); end
            end
            chk("fair.count", who.size(), 6);
            for (int i = 0; i < who.size(); i++) begin
                chk($sformatf("fair.order%0d", i), who[i], i % 2);
                chk($sformatf("fair.cycle%0d", i), when[i], 2 + 3 * i);
            end
        end

        // Randomized run against the transaction-level reference.
        @(posedge CLK); #1;
        drive(1, 0,0,0,0,0,0, 0,0,0,0,0, 0);
        model_reset(-1);
        for (int c = 0; c < 600; c++) begin
            logic rst, r0, r1, k0;
            logic [31:0] iord;
            logic x_req, x_ack0, x_ack1;
            @(posedge CLK); #1;
            rst  = ($urandom_range(63) == 0);
            r0   = $urandom_range(1);
            r1   = $urandom_range(1);
            k0   = ($urandom_range(3) == 0);
            iord = $urandom;
            drive(rst, r0, $urandom_range(1), $urandom_range(1), k0, 14'($urandom), $urandom,
                  r1, $urandom_range(1), $urandom_range(1), 14'($urandom), $urandom, iord);
            @(negedge CLK);
            x_req  = (c == m_iss);
            x_ack0 = (c == m_ack) && (m_win == 0);
            x_ack1 = (c == m_ack) && (m_win == 1);
            if (x_req) m_killed = (m_win == 0) && k0;
            check_outs($sformatf("rnd%0d", c), x_req, x_req && (m_win == 0) && k0, x_req && m_we,
                       x_req && m_re, m_addr, m_wd, x_ack0, x_ack0 ? iord : 32'd0,
                       x_ack1, x_ack1 ? iord : 32'd0, (c == m_iss) || (c == m_ack),
                       x_ack0 && m_killed);
            if (rst) begin
                model_reset(c);
            end else if (c >= m_free && (r0 || r1)) begin
                m_win  = (r0 && r1) ? (1 - m_last) : (r1 ? 1 : 0);
                m_last = m_win;
                m_we   = m_win ? M1_WE : M0_WE;
                m_re   = m_win ? M1_RE : M0_RE;
                m_addr = m_win ? M1_ADDR : M0_ADDR;
                m_wd   = m_win ? M1_WD : M0_WD;
                m_iss  = c + 1;
                m_ack  = c + 2;
                m_free = c + 3;
                m_killed = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_arbiter.md
Name: io_arbiter

Overview:
- Two-master arbiter and sequencer in front of io_space.
- Master 0 is the CPU load/store path; master 1 is the debug/DMA port.
- Grants the single IO request channel round-robin, issues one registered command per transaction, and returns read data and an acknowledge to the winning master.
- Accounts for io_space's internal one-cycle input register stage.

Parameters:
- RAM_DEPTH, 14, width of the IO address bus; must match io_space.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- M0_REQ  in  1  master 0 request; held high until M0_ACK.
- M0_WE  in  1  master 0 write.
- M0_RE  in  1  master 0 read.
- M0_KILL  in  1  master 0 abort (pipeline flush); sampled in ISSUE only.
- M0_ADDR  in  RAM_DEPTH  master 0 address.
- M0_WD  in  32  master 0 write data.
- M0_ACK  out  1  master 0 transaction complete (one-cycle pulse).
- M0_RD  out  32  master 0 read data; valid while M0_ACK=1.
- M1_REQ, M1_WE, M1_RE, M1_ADDR, M1_WD, M1_ACK, M1_RD: same as master 0 (no KILL).
- IO_REQ  out  1  to io_space IO_REQ.
- IO_DBE  out  1  to io_space DBE.
- IO_WE  out  1  to io_space IO_WE.
- IO_RE  out  1  to io_space IO_RE.
- IO_ADDR  out  RAM_DEPTH  to io_space IO_ADDR.
- IO_WD  out  32  to io_space IO_WD.
- IO_RD  in  32  from io_space IO_RD.
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- FSM states IDLE, ISSUE, WAIT; reset state IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick winner, latch winner's WE/RE/ADDR/WD and the winner index into command registers, go to ISSUE.
- ISSUE:
  - IO_REQ=1 for exactly one cycle.
  - IO_WE/IO_RE/IO_ADDR/IO_WD come from the command registers, not the master inputs.
  - IO_DBE = M0_KILL when winner=0, else 0.
  - Always go to WAIT.
- WAIT:
  - io_space holds the registered command and IO_RD is valid.
  - Assert winner's ACK=1; winner's RD = IO_RD (combinational pass-through).
  - Go to IDLE.
- Latency: REQ seen in cycle t → IO_REQ in t+1 → ACK in t+2.
  - Back-to-back throughput is one transaction per 3 cycles.
  - A master seeing ACK in t+2 and keeping REQ high issues a new request, which is evaluated in IDLE at t+3.
- Arbitration:
  - Round-robin on a last_grant register, updated on each IDLE→ISSUE transition.
  - Simultaneous requests: grant the master ≠ last_grant.
  - Single request: grant it regardless of last_grant.
  - last_grant resets to 1, so master 0 wins the first tie.
- Killed transaction (M0_KILL in ISSUE):
  - io_space suppresses the write.
  - M0_ACK is still pulsed in WAIT; M0_RD content is don't-care.
  - M0_KILL outside ISSUE has no effect.
- REQ with WE=RE=0: treated as a no-op. Cycle sequence is unchanged and ACK is still returned.
- WE=RE=1: forwarded as-is; no checking.
- Master inputs changing after grant do not affect the in-flight transaction (command is latched).
- Outputs outside ISSUE:
  - IO_REQ=0, IO_DBE=0, IO_WE=0, IO_RE=0.
  - IO_ADDR and IO_WD hold the last latched command.
- Non-winning master's ACK stays 0; its RD is 0.
- Reset:
  - Reset values: all command registers 0, IO_* outputs 0, ACKs 0, RDs 0, BUSY 0, last_grant 1.
  - Reset mid-transaction (ISSUE or WAIT) returns to IDLE on the next edge. No ACK is generated and IO_REQ deasserts.

Test Plan:
- Single read: M0_REQ=1, RE=1, ADDR=0x003 at cycle 0 → IO_REQ=1, IO_ADDR=0x003, IO_RE=1 in cycle 1. In cycle 2, M0_ACK=1 and M0_RD = IO_RD (bench drives 0xDEADBEEF). BUSY is high in cycles 1–2.
- Simultaneous requests after reset: M0 write 0x12345678 @0x001 and M1 read @0x002 → M0 is granted first (ACK cycle 2). M1 is issued in cycle 4, with M1_ACK in cycle 5.
- Fairness: both masters hold REQ continuously for 6 transactions → grant order 0,1,0,1,0,1, with ACKs 3 cycles apart.
- Kill: M0 write with M0_KILL=1 in the ISSUE cycle → IO_DBE=1 and IO_WE=1 in that cycle. M0_ACK is pulsed in the next cycle. The same sequence with KILL asserted in IDLE or WAIT gives IO_DBE=0.
- Command stability: M1 changes ADDR from 0x010 to 0x020 in the cycle after grant → IO_ADDR=0x010 in ISSUE.
- Reset in ISSUE: RESET=1 during ISSUE → next cycle IDLE, IO_REQ=0, no ACK. Afterwards a fresh M1 request is granted normally.
